reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two, 2..64.
REQ-003 SHALL have parameter NRD, default 2, read port count, 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 reads 0 and ignores writes.
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data is forwarded to reads.
REQ-006 SHALL use AW = log2(NREGS) as the address width.
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-009 SHALL have port ra, input, NRD*AW, packed read addresses; port i is bits [i*AW +: AW].
REQ-010 SHALL have port rd, output, NRD*XLEN, packed read data, one XLEN slice per read port.
REQ-011 SHALL have port rbusy, output, NRD, pending-write flag of each read port's addressed register.
REQ-012 SHALL have port we0, input, 1, write enable for write port 0.
REQ-013 SHALL have port wa0, input, AW, write address for write port 0.
REQ-014 SHALL have port wd0, input, XLEN, write data for write port 0.
REQ-015 SHALL have ports we1/wa1/wd1, input, 1/AW/XLEN, write port 1 (enable/address/data).
REQ-016 SHALL have port iss_en, input, 1, issue strobe that marks register iss_a as busy.
REQ-017 SHALL have port iss_a, input, AW, destination register of the issued instruction.

Function
REQ-018 SHALL write wd0 to wa0 when we0=1, and wd1 to wa1 when we1=1, at the rising clk edge.
REQ-019 SHALL write only wd1 when both ports write the same address in one cycle (port 1 priority).
REQ-020 SHALL ignore writes and issues to address 0 when ZERO_REG=1.
REQ-021 SHALL make rd combinational from ra with zero-cycle read latency.
REQ-022 SHALL return 0 on rd for address 0 when ZERO_REG=1, regardless of bypass.
REQ-023 SHALL, when BYPASS=1, drive rd from the same-cycle enabled write data whose address matches ra; port-1 data wins over port-0 data.
REQ-024 SHALL, when BYPASS=0, return the pre-edge stored value during a same-cycle write.
REQ-025 SHALL keep one busy bit per register in a scoreboard.
REQ-026 SHALL set busy[iss_a] at the edge when iss_en=1.
REQ-027 SHALL clear busy[wa0] and busy[wa1] at the edge when the matching write enable is 1.
REQ-028 SHALL let set win over clear when an issue and a write hit the same register in one cycle.
REQ-029 SHALL drive rbusy[i] = busy[ra_i] combinationally, and force it to 0 for address 0 when ZERO_REG=1.
REQ-030 SHALL, when BYPASS=1, drive rbusy[i]=0 for a register being cleared in the same cycle by a write, unless that register is also being issued in the same cycle.
REQ-031 SHALL treat every address bit pattern as valid, so no out-of-range case exists.

Reset
REQ-032 SHALL, on rst=1, clear all registers and all busy bits immediately, without waiting for clk.
REQ-033 SHALL therefore drive rd=0 and rbusy=0 on every port while rst=1.
REQ-034 SHALL ignore writes and issues on any edge while rst=1.
REQ-035 SHALL let an rst assertion that coincides with a write leave the register at 0.

Structure
REQ-036 SHALL place the log2 helper function and the default XLEN/NREGS constants in shared package rf_pkg.
REQ-037 SHALL implement the busy bits and the set/clear logic in sub-module reg_scoreboard (parameters NREGS, NRD), instantiated once.
REQ-038 SHALL store the registers as an array of NREGS words, not as a flattened vector.

Verification
REQ-039 SHALL cover a write/read check: we0=1, wa0=5, wd0=0xDEADBEEF, then the next cycle ra port0=5 -> rd slice0=0xDEADBEEF.
REQ-040 SHALL cover a write collision: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> same-cycle rd(7)=0x22 (BYPASS=1) and stored value 0x22.
REQ-041 SHALL cover register 0: write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> rd(0)=0 and rbusy=0; with ZERO_REG=0 -> rd(0)=0xFFFFFFFF.
REQ-042 SHALL cover the scoreboard: iss_en=1, iss_a=3 -> rbusy(3)=1 the next cycle; then we1=1, wa1=3 -> rbusy(3)=0 in the same cycle, and stored busy cleared.
REQ-043 SHALL cover simultaneous issue and writeback: iss_a=9 and wa0=9 in one cycle -> busy[9]=1 after the edge.
REQ-044 SHALL cover asynchronous reset: fill registers 1..31, then pulse rst between clock edges -> all rd=0 and rbusy=0 before the next edge.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Ceiling log2; NREGS is a power of two so this yields the exact address width.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundled read/write/issue signals of the multi-port register file.
interface reg_file_mp_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    localparam int unsigned AW   = log2(NREGS)
) ();

    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we1;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic                iss_en;
    logic [AW-1:0]       iss_a;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_a,
        input  rd, rbusy
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_a,
        output rd, rbusy
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register pending-write scoreboard: issue sets a busy bit, writeback clears it.
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    localparam int unsigned AW   = log2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AW-1:0]     set_a,
    input  logic              clr0_en,
    input  logic [AW-1:0]     clr0_a,
    input  logic              clr1_en,
    input  logic [AW-1:0]     clr1_a,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    busy_rd,
    output logic [NRD-1:0]    clr_pend
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW-1:0]    rd_a;

    // Set is applied last so an issue overrides a writeback to the same register.
    always_comb begin
        busy_d = busy_q;
        if (clr0_en) busy_d[clr0_a] = 1'b0;
        if (clr1_en) busy_d[clr1_a] = 1'b0;
        if (set_en)  busy_d[set_a]  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_rd  = '0;
        clr_pend = '0;
        rd_a     = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_a        = ra[i*AW +: AW];
            busy_rd[i]  = busy_q[rd_a];
            clr_pend[i] = ((clr0_en && clr0_a == rd_a) || (clr1_en && clr1_a == rd_a))
                          && !(set_en && set_a == rd_a);
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational reads, two writes, busy scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = log2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_a
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr0_en;
    logic            wr1_en;
    logic            iss_ok;
    logic [NRD-1:0]  busy_rd;
    logic [NRD-1:0]  clr_pend;
    logic [AW-1:0]   rd_a;
    logic [XLEN-1:0] rd_v;

    always_comb begin
        wr0_en = we0 && !(ZR && wa0 == '0);
        wr1_en = we1 && !(ZR && wa1 == '0);
        iss_ok = iss_en && !(ZR && iss_a == '0);
    end

    // Port 1 is applied after port 0 so it wins an address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr0_en) regs_d[wa0] = wd0;
        if (wr1_en) regs_d[wa1] = wd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_ok),
        .set_a    (iss_a),
        .clr0_en  (wr0_en),
        .clr0_a   (wa0),
        .clr1_en  (wr1_en),
        .clr1_a   (wa1),
        .ra       (ra),
        .busy_rd  (busy_rd),
        .clr_pend (clr_pend)
    );

    // Outputs are gated by rst so reads show zero for the whole reset pulse.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        rd_a  = '0;
        rd_v  = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_a = ra[i*AW +: AW];
            rd_v = regs_q[rd_a];
            if (BP) begin
                if (wr0_en && wa0 == rd_a) rd_v = wd0;
                if (wr1_en && wa1 == rd_a) rd_v = wd1;
            end
            if (rst || (ZR && rd_a == '0)) rd_v = '0;
            rd[i*XLEN +: XLEN] = rd_v;
            rbusy[i] = busy_rd[i] && !(BP && clr_pend[i]) && !(ZR && rd_a == '0) && !rst;
        end
    end

endmodule
